// File: rtl/wsg_pkg.sv
// Shared definitions for window_stream_gen: size encodings, FSM states and
// window-geometry helpers.
package wsg_pkg;

  localparam logic [1:0] SZ_2X2  = 2'd0;
  localparam logic [1:0] SZ_3X3  = 2'd1;
  localparam logic [1:0] SZ_RSVD = 2'd2;
  localparam logic [1:0] SZ_5X5  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_FLUSH
  } state_e;

  // Lines/columns the newest pixel runs ahead of the window anchor.
  function automatic int unsigned lead_h(logic [1:0] size);
    return (size == SZ_5X5) ? 2 : 1;
  endfunction

  function automatic int unsigned lead(logic [1:0] size, int unsigned img_w);
    return lead_h(size) * img_w + lead_h(size);
  endfunction

  // Distance (in lines and columns) from the window's first element to its last.
  function automatic int unsigned win_span(logic [1:0] size);
    case (size)
      SZ_2X2:  return 1;
      SZ_5X5:  return 4;
      default: return 2;
    endcase
  endfunction

endpackage

// File: rtl/wsg_if.sv
// Pixel-in / window-out stream bundle for window_stream_gen.
// master = window generator side, slave = surrounding pipeline side.
interface wsg_if #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned PIX_W = 8,
  parameter int unsigned KMAX  = 5
);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned COL_W = $clog2(IMG_W);

  logic                      in_valid;
  logic                      in_ready;
  logic [PIX_W-1:0]          in_pixel;
  logic                      out_valid;
  logic                      out_ready;
  logic [KMAX*KMAX*PIX_W-1:0] out_window;
  logic [ROW_W-1:0]          out_row;
  logic [COL_W-1:0]          out_col;
  logic                      out_last;

  modport master (
    input  in_valid, in_pixel, out_ready,
    output in_ready, out_valid, out_window, out_row, out_col, out_last
  );

  modport slave (
    output in_valid, in_pixel, out_ready,
    input  in_ready, out_valid, out_window, out_row, out_col, out_last
  );
endinterface

// File: rtl/wsg_line_ram.sv
// One line of pixel history: asynchronous read, synchronous write at the same
// address, so a read returns the value stored one line earlier.
module wsg_line_ram #(
  parameter int unsigned DEPTH = 640,
  parameter int unsigned PIX_W = 8
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [PIX_W-1:0]         wr_data,
  output logic [PIX_W-1:0]         rd_data
);
  logic [PIX_W-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[addr] <= wr_data;
  end
endmodule

// File: rtl/window_stream_gen.sv
// Streaming zero-padded neighbourhood-window generator (2x2 / 3x3 / 5x5).
// Optional WSG_FRAME_STATS_EN adds frame_cnt and stall_cnt outputs.
module window_stream_gen
  import wsg_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  parameter int unsigned PIX_W = 8,
  parameter int unsigned KMAX  = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  size,
  wsg_if.master       bus,
  output logic        size_err
`ifdef WSG_FRAME_STATS_EN
  ,
  output logic [15:0] frame_cnt,
  output logic [31:0] stall_cnt
`endif
);
  localparam int unsigned ROW_W = $clog2(IMG_H);
  localparam int unsigned COL_W = $clog2(IMG_W);
  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned IDX_W = $clog2(NPIX);
  localparam int unsigned IW    = $clog2(KMAX);
  localparam int unsigned WB    = KMAX * KMAX * PIX_W;

  state_e               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic                 size_err_q, size_err_d;
  logic [COL_W-1:0]     in_col_q, in_col_d;
  logic [IDX_W-1:0]     in_idx_q, in_idx_d;
  logic [ROW_W-1:0]     nxt_row_q, nxt_row_d;
  logic [COL_W-1:0]     nxt_col_q, nxt_col_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [ROW_W-1:0]     out_row_q, out_row_d;
  logic [COL_W-1:0]     out_col_q, out_col_d;
  logic [WB-1:0]        out_win_q, out_win_d, win_masked;
  logic [PIX_W-1:0]     win_q [KMAX][KMAX];
  logic [PIX_W-1:0]     win_d [KMAX][KMAX];
  logic [PIX_W-1:0]     lb_rd [KMAX-1];
  logic                 in_rdy, inject, in_fire, out_fire, adv, load;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  state_d = ST_FILL;
      ST_FILL:  if (in_fire && in_idx_q == IDX_W'(lead(mode_q, IMG_W) - 1)) state_d = ST_RUN;
      ST_RUN:   if (in_fire && in_idx_q == IDX_W'(NPIX - 1)) state_d = ST_FLUSH;
      ST_FLUSH: if (out_fire && out_last_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs; FLUSH feeds virtual zero pixels until the last window is loaded
  always_comb begin
    in_rdy = 1'b0;
    inject = 1'b0;
    unique case (state_q)
      ST_FILL:  in_rdy = 1'b1;
      ST_RUN:   in_rdy = !out_valid_q || bus.out_ready;
      ST_FLUSH: inject = (!out_valid_q || bus.out_ready) && !out_last_q;
      default:  ;
    endcase
  end

  assign in_fire  = bus.in_valid && in_rdy;
  assign out_fire = out_valid_q && bus.out_ready;
  assign adv      = in_fire || inject;
  assign load     = (in_fire && state_q == ST_RUN) || inject;

  for (genvar g = 0; g < KMAX - 1; g++) begin : g_lb
    wsg_line_ram #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_ram (
      .clk     (clk),
      .wr_en   (adv),
      .addr    (in_col_q),
      .wr_data ((g == 0) ? win_d[0][0] : lb_rd[g-1]),
      .rd_data (lb_rd[g])
    );
  end

  // win[i][k] holds the pixel i lines and k beats behind the newest one
  always_comb begin
    win_d = win_q;
    if (adv) begin
      for (int unsigned i = 0; i < KMAX; i++) begin
        for (int unsigned k = KMAX - 1; k > 0; k--) win_d[i][k] = win_q[i][k-1];
      end
      win_d[0][0] = (state_q == ST_FLUSH) ? '0 : bus.in_pixel;
      for (int unsigned i = 1; i < KMAX; i++) win_d[i][0] = lb_rd[i-1];
    end
  end

  // Pick window elements relative to the newest pixel and zero anything whose
  // source lies outside the frame; this also hides stale line-buffer contents.
  always_comb begin
    int unsigned d_span, off;
    int          src_r, src_c;
    logic [IW-1:0] wi, wc;
    d_span     = win_span(mode_q);
    off        = d_span - lead_h(mode_q);
    src_r      = 0;
    src_c      = 0;
    wi         = '0;
    wc         = '0;
    win_masked = '0;
    for (int unsigned r = 0; r < KMAX; r++) begin
      for (int unsigned c = 0; c < KMAX; c++) begin
        src_r = int'(nxt_row_q) + int'(r) - int'(off);
        src_c = int'(nxt_col_q) + int'(c) - int'(off);
        if (r <= d_span && c <= d_span && src_r >= 0 && src_r < int'(IMG_H) &&
            src_c >= 0 && src_c < int'(IMG_W)) begin
          wi = IW'(d_span - r);
          wc = IW'(d_span - c);
          win_masked[(r*KMAX+c)*PIX_W +: PIX_W] = win_d[wi][wc];
        end
      end
    end
  end

  always_comb begin
    mode_d     = mode_q;
    size_err_d = size_err_q;
    in_col_d   = in_col_q;
    in_idx_d   = in_idx_q;
    if (state_q == ST_IDLE) begin
      in_col_d = '0;
      in_idx_d = '0;
    end else if (adv) begin
      in_col_d = (in_col_q == COL_W'(IMG_W - 1)) ? '0 : in_col_q + 1'b1;
      if (in_fire) in_idx_d = in_idx_q + 1'b1;
    end
    if (in_fire && state_q == ST_FILL && in_idx_q == '0) begin
      mode_d = (size == SZ_RSVD || (size == SZ_5X5 && KMAX < 5)) ? SZ_3X3 : size;
      if (size == SZ_RSVD) size_err_d = 1'b1;
    end
  end

  always_comb begin
    nxt_row_d   = nxt_row_q;
    nxt_col_d   = nxt_col_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_win_d   = out_win_q;
    if (state_q == ST_IDLE) begin
      nxt_row_d = '0;
      nxt_col_d = '0;
    end
    if (load) begin
      out_valid_d = 1'b1;
      out_row_d   = nxt_row_q;
      out_col_d   = nxt_col_q;
      out_win_d   = win_masked;
      out_last_d  = (nxt_row_q == ROW_W'(IMG_H - 1)) && (nxt_col_q == COL_W'(IMG_W - 1));
      if (nxt_col_q == COL_W'(IMG_W - 1)) begin
        nxt_col_d = '0;
        nxt_row_d = nxt_row_q + 1'b1;
      end else begin
        nxt_col_d = nxt_col_q + 1'b1;
      end
    end else if (out_fire) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q      <= SZ_3X3;
      size_err_q  <= 1'b0;
      in_col_q    <= '0;
      in_idx_q    <= '0;
      nxt_row_q   <= '0;
      nxt_col_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_win_q   <= '0;
    end else begin
      mode_q      <= mode_d;
      size_err_q  <= size_err_d;
      in_col_q    <= in_col_d;
      in_idx_q    <= in_idx_d;
      nxt_row_q   <= nxt_row_d;
      nxt_col_q   <= nxt_col_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_win_q   <= out_win_d;
    end
  end

  always_ff @(posedge clk) begin
    win_q <= win_d;
  end

  assign bus.in_ready   = in_rdy;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_window = out_win_q;
  assign bus.out_row    = out_row_q;
  assign bus.out_col    = out_col_q;
  assign bus.out_last   = out_last_q;
  assign size_err       = size_err_q;

`ifdef WSG_FRAME_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (out_fire && out_last_q) frame_cnt_d = frame_cnt_q + 16'd1;
    if (out_valid_q && !bus.out_ready && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_window_stream_gen.sv
// Self-checking bench for window_stream_gen at 8x6 pixels, KMAX=5; expected
// windows come from a coordinate-level model of the zero-padded neighbourhood.
module tb_window_stream_gen;
  localparam int unsigned IMG_W = 8;
  localparam int unsigned IMG_H = 6;
  localparam int unsigned PIX_W = 8;
  localparam int unsigned KMAX  = 5;
  localparam int unsigned NPIX  = IMG_W * IMG_H;
  localparam int unsigned WB    = KMAX * KMAX * PIX_W;

  typedef struct {
    logic [WB-1:0] w;
    int            row;
    int            col;
    bit            last;
  } win_t;

  typedef struct {
    logic [1:0] sz;
    int         ar;
    int         ac;
    int         r;
    int         c;
    int         expv;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] size = 2'd1;
  logic       size_err;
`ifdef WSG_FRAME_STATS_EN
  logic [15:0] frame_cnt;
  logic [31:0] stall_cnt;
`endif

  wsg_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .KMAX(KMAX)) bus ();

  window_stream_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .KMAX(KMAX)) dut (
    .clk      (clk),
    .reset    (reset),
    .size     (size),
    .bus      (bus),
    .size_err (size_err)
`ifdef WSG_FRAME_STATS_EN
    ,
    .frame_cnt(frame_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_err = 0;
  int            n_stall = 0;
  logic [7:0]    img [NPIX];
  logic [WB-1:0] cap [4][NPIX];
  vec_t          vecs [$];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Element (r,c) of the window anchored at (ar,ac) is the image pixel at
  // (ar+r-off, ac+c-off), or zero off the image / outside the k x k window.
  function automatic logic [WB-1:0] model_win(input logic [1:0] m, input int ar, input int ac);
    logic [WB-1:0] w;
    int k, off, sr, sc;
    k   = (m == 2'd0) ? 2 : (m == 2'd3) ? 5 : 3;
    off = (m == 2'd0) ? 0 : (k - 1) / 2;
    w   = '0;
    for (int r = 0; r < k; r++) begin
      for (int c = 0; c < k; c++) begin
        sr = ar + r - off;
        sc = ac + c - off;
        if (sr >= 0 && sr < int'(IMG_H) && sc >= 0 && sc < int'(IMG_W))
          w[(r*KMAX+c)*PIX_W +: PIX_W] = img[sr*IMG_W+sc];
      end
    end
    return w;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_last", bus.out_last, 0);
    check("rst_out_row", bus.out_row, 0);
    check("rst_out_col", bus.out_col, 0);
    check("rst_size_err", size_err, 0);
    n_stall = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_frame(input logic [1:0] sz, input int ready_pct, input int valid_pct,
                           input int abort_at, input bit chk_lat);
    win_t       exp_q [$];
    win_t       e;
    logic [1:0] m;
    int         p, tenth, first, got, lead_idx;
    bit         done;
    m        = (sz == 2'd2) ? 2'd1 : sz;
    lead_idx = (m == 2'd3) ? 2 * IMG_W + 2 : IMG_W + 1;
    for (int a = 0; a < int'(NPIX); a++) begin
      e.w    = model_win(m, a / IMG_W, a % IMG_W);
      e.row  = a / IMG_W;
      e.col  = a % IMG_W;
      e.last = (a == int'(NPIX) - 1);
      exp_q.push_back(e);
    end
    p = 0; tenth = -1; first = -1; got = 0; done = 1'b0;
    for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
      @(negedge clk);
      bus.out_ready = ($urandom_range(99) < ready_pct);
      bus.in_valid  = (p < int'(NPIX)) && ($urandom_range(99) < valid_pct);
      if (bus.in_valid) bus.in_pixel = img[p];
      else              bus.in_pixel = 8'($urandom);
      size = (p == 0) ? sz : 2'($urandom);
      #1;
      if (bus.out_valid && first < 0) first = cyc;
      if (bus.out_valid && !bus.out_ready) begin
        n_stall++;
        check("no_accept_while_stalled", bus.in_ready, 0);
      end
      if (bus.in_valid && bus.in_ready) begin
        if (p == lead_idx) tenth = cyc;
        p++;
        if (p == abort_at) return;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_window", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("win(%0d,%0d)", e.row, e.col), bus.out_window, e.w);
          check("out_row", bus.out_row, e.row);
          check("out_col", bus.out_col, e.col);
          check("out_last", bus.out_last, e.last);
          cap[m][e.row*IMG_W+e.col] = bus.out_window;
          got++;
          if (bus.out_last) done = 1'b1;
        end
      end
    end
    bus.in_valid = 1'b0;
    if (!done) check("frame_timeout", 0, 1);
    check("windows_per_frame", got, NPIX);
    if (chk_lat) check("first_out_latency", first, tenth + 1);
  endtask

  task automatic add_vec(input logic [1:0] sz, input int ar, input int ac, input int r, input int c, input int v);
    vec_t t;
    t.sz = sz; t.ar = ar; t.ac = ac; t.r = r; t.c = c; t.expv = v;
    vecs.push_back(t);
  endtask

  initial begin
    logic [WB-1:0] w;
    logic [7:0]    el;
    logic [1:0]    rs;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_pixel  = '0;

    add_vec(2'd1, 0, 0, 0, 0, 0);  add_vec(2'd1, 0, 0, 1, 2, 1);
    add_vec(2'd1, 0, 0, 2, 1, 8);  add_vec(2'd1, 0, 0, 2, 2, 9);
    add_vec(2'd1, 0, 0, 3, 3, 0);  add_vec(2'd3, 2, 2, 0, 0, 0);
    add_vec(2'd3, 2, 2, 0, 4, 4);  add_vec(2'd3, 2, 2, 2, 2, 18);
    add_vec(2'd3, 2, 2, 4, 4, 36); add_vec(2'd3, 0, 0, 2, 3, 1);
    add_vec(2'd3, 0, 0, 4, 4, 18); add_vec(2'd3, 0, 0, 1, 4, 0);
    add_vec(2'd0, 5, 7, 0, 0, 47); add_vec(2'd0, 5, 7, 0, 1, 0);
    add_vec(2'd0, 5, 7, 1, 0, 0);  add_vec(2'd0, 3, 4, 0, 0, 28);
    add_vec(2'd0, 3, 4, 0, 1, 29); add_vec(2'd0, 3, 4, 1, 0, 36);
    add_vec(2'd0, 3, 4, 1, 1, 37); add_vec(2'd0, 3, 4, 2, 2, 0);

    do_reset();
    for (int i = 0; i < int'(NPIX); i++) img[i] = 8'(i);
    run_frame(2'd1, 100, 100, -1, 1'b1);
    run_frame(2'd3, 100, 100, -1, 1'b0);
    run_frame(2'd0, 100, 100, -1, 1'b0);
    foreach (vecs[i]) begin
      w  = cap[vecs[i].sz][vecs[i].ar*IMG_W+vecs[i].ac];
      el = w[(vecs[i].r*KMAX+vecs[i].c)*PIX_W +: PIX_W];
      check($sformatf("vec%0d sz%0d (%0d,%0d)[%0d][%0d]", i, vecs[i].sz, vecs[i].ar, vecs[i].ac,
                      vecs[i].r, vecs[i].c), el, vecs[i].expv);
    end

    run_frame(2'd1, 30, 80, -1, 1'b0);

    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < int'(NPIX); i++) img[i] = 8'($urandom);
      case ($urandom_range(2))
        0:       rs = 2'd0;
        1:       rs = 2'd1;
        default: rs = 2'd3;
      endcase
      run_frame(rs, $urandom_range(30, 100), $urandom_range(50, 100), -1, 1'b0);
    end

    for (int i = 0; i < int'(NPIX); i++) img[i] = 8'($urandom_range(1, 255));
    run_frame(2'd1, 100, 100, 20, 1'b0);
    do_reset();
    for (int i = 0; i < int'(NPIX); i++) img[i] = 8'(i);
    run_frame(2'd1, 100, 100, -1, 1'b1);
    check("size_err_clear", size_err, 0);
`ifdef WSG_FRAME_STATS_EN
    check("frame_cnt_after_one", frame_cnt, 1);
`endif

    run_frame(2'd2, 50, 90, -1, 1'b0);
    check("size_err_set", size_err, 1);
`ifdef WSG_FRAME_STATS_EN
    check("frame_cnt_after_two", frame_cnt, 2);
    check("stall_cnt", stall_cnt, n_stall);
`endif
    run_frame(2'd1, 100, 100, -1, 1'b0);
    check("size_err_sticky", size_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
